// File: rtl/coef_normalizer.sv
// Carry-propagating normalizer: turns a packed redundant-form coefficient vector
// into a plain binary integer, LANES coefficients per cycle, ready/valid on both sides.

module coef_normalizer_lane #(
   parameter int COEF_BITS  = 34,
   parameter int WORD_LEN   = 17,
   parameter int CARRY_BITS = 18
) (
   input  logic                  en,
   input  logic [COEF_BITS-1:0]  coef,
   input  logic [CARRY_BITS-1:0] carry_in,
   output logic [WORD_LEN-1:0]   word,
   output logic [CARRY_BITS-1:0] carry_out
);
   localparam int SUM_W = ((COEF_BITS > CARRY_BITS) ? COEF_BITS : CARRY_BITS) + 1;

   logic [SUM_W-1:0] sum;

   assign sum       = SUM_W'(coef) + SUM_W'(carry_in);
   assign word      = sum[WORD_LEN-1:0];
   // Lanes past the last coefficient pass the carry through untouched
   assign carry_out = en ? CARRY_BITS'(sum >> WORD_LEN) : carry_in;
endmodule

module coef_normalizer #(
   parameter int WORD_LEN     = 17,
   parameter int NUM_ELEMENTS = 62,
   parameter int COEF_BITS    = 2*WORD_LEN,
   parameter int LANES        = 4,
   parameter int OUT_LEN      = NUM_ELEMENTS*WORD_LEN,
   parameter int CARRY_BITS   = COEF_BITS-WORD_LEN+1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NUM_ELEMENTS*COEF_BITS-1:0] coef_in,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_LEN-1:0]                result,
   output logic [CARRY_BITS-1:0]             carry_out,
   output logic                              busy
);
   localparam int IDX_W = $clog2(NUM_ELEMENTS+LANES+1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                                    state_q, state_d;
   logic [NUM_ELEMENTS-1:0][COEF_BITS-1:0]    buf_q;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     res_q;
   logic [CARRY_BITS-1:0]                     carry_q, cout_q;
   logic [IDX_W-1:0]                          idx_q;
   logic [LANES:0][CARRY_BITS-1:0]            cchain;
   logic [LANES-1:0][WORD_LEN-1:0]            lane_word;
   logic [LANES-1:0]                          lane_en;
   logic                                      last;

   assign cchain[0] = carry_q;
   assign last      = (idx_q + IDX_W'(LANES)) >= IDX_W'(NUM_ELEMENTS);

   // The buffer shifts down by LANES each RUN cycle, so lane l always reads slot l
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_en[l] = idx_q < IDX_W'(NUM_ELEMENTS - l);
      coef_normalizer_lane #(
         .COEF_BITS (COEF_BITS),
         .WORD_LEN  (WORD_LEN),
         .CARRY_BITS(CARRY_BITS)
      ) u_lane (
         .en       (lane_en[l]),
         .coef     (buf_q[l]),
         .carry_in (cchain[l]),
         .word     (lane_word[l]),
         .carry_out(cchain[l+1])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q   <= '0;
         res_q   <= '0;
         carry_q <= '0;
         cout_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               buf_q   <= coef_in;
               carry_q <= '0;
               idx_q   <= '0;
            end
            RUN: begin
               buf_q   <= buf_q >> (LANES*COEF_BITS);
               carry_q <= cchain[LANES];
               idx_q   <= idx_q + IDX_W'(LANES);
               for (int k = 0; k < NUM_ELEMENTS; k++)
                  for (int l = 0; l < LANES; l++)
                     if (k >= l && idx_q == IDX_W'(k - l)) res_q[k] <= lane_word[l];
               if (last) cout_q <= cchain[LANES];
            end
            default: ;
         endcase
      end
   end

   assign result    = res_q;
   assign carry_out = cout_q;
endmodule

// File: doc/coef_normalizer.md
Name: coef_normalizer

Overview:
- Sits directly downstream of the modular squaring wrapper.
- Consumes its packed redundant-form coefficient vector, where each coefficient lives in a 2*WORD_LEN slot with value sum c[j]*2^(j*WORD_LEN).
- Carry-propagates the vector, LANES coefficients per cycle, into a plain binary integer for the host/readback path.
- Uses ready/valid handshakes on both sides and holds the result until it is consumed.

Parameters:
- WORD_LEN, 17, bits per normalized output word.
- NUM_ELEMENTS, 62, number of input coefficients (60 non-redundant + 2 redundant).
- COEF_BITS, 34, width of each input coefficient slot (2*WORD_LEN).
- LANES, 4, coefficients processed per RUN cycle; must be 1..NUM_ELEMENTS.
- OUT_LEN, NUM_ELEMENTS*WORD_LEN, width of the binary result.
- CARRY_BITS, COEF_BITS-WORD_LEN+1, width of the inter-word carry register.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  coef_in holds a complete squarer output
- in_ready  out  1  block can accept input; high only in IDLE
- coef_in  in  NUM_ELEMENTS*COEF_BITS  packed coefficients; coefficient j at [j*COEF_BITS +: COEF_BITS]
- out_valid  out  1  result/carry_out valid
- out_ready  in  1  consumer accepts result
- result  out  OUT_LEN  normalized value; word k at [k*WORD_LEN +: WORD_LEN]
- carry_out  out  CARRY_BITS  carry out of the top word; value = result + carry_out*2^OUT_LEN
- busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asserted low, takes effect immediately, no clock needed):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, carry_out=0, internal carry=0, index=0, coefficient buffer=0.
- Reset mid-RUN or mid-DONE aborts the operation. No output is produced for the aborted input.
- IDLE:
  - On an edge with in_valid&in_ready, capture all of coef_in into the buffer, clear carry and index, go to RUN.
  - in_valid while not in IDLE is ignored; coef_in is sampled only on that accept edge.
- RUN, per edge, for lane l=0..LANES-1 with k=index+l and k<NUM_ELEMENTS:
  - s = buf[k] + carry (carry is the value from the previous lane in the same cycle, or from the register for l=0).
  - result word k = s[WORD_LEN-1:0].
  - carry = s >> WORD_LEN, truncated to CARRY_BITS; this width is lossless for COEF_BITS-wide inputs.
  - Lanes with k>=NUM_ELEMENTS do nothing.
  - index += LANES.
- RUN exit: when index+LANES >= NUM_ELEMENTS on that edge, latch carry_out = final carry and go to DONE.
- RUN length = ceil(NUM_ELEMENTS/LANES) edges; 16 at defaults, last edge uses 2 lanes.
- Latency: accept at edge E0 gives out_valid=1 after edge E0+ceil(NUM_ELEMENTS/LANES); 16 at defaults.
- DONE:
  - out_valid=1; result and carry_out stable.
  - On an edge with out_ready=1: out_valid->0, go to IDLE. in_ready rises the same edge.
- No input/output overlap: the next accept is at earliest one edge after the output handshake. Back-to-back throughput is one result per ceil(N/L)+2 cycles.
- out_ready is ignored outside DONE.
- result is not cleared between operations. Words not yet written in RUN keep their previous values; only the values presented in DONE are defined.
- No modular reduction is performed; the output may exceed the modulus.

Test Plan:
- Zero input: all coef=0 -> after 16 cycles out_valid=1, result=0, carry_out=0.
- Single carry: coef[0]=2^17, others 0 -> word0=0, word1=1, other words 0, carry_out=0.
- Full ripple: coef[0]=2^17, coef[1..61]=2^17-1 -> every result word 0, carry_out=1. This checks carries across lane and cycle boundaries including the partial last cycle.
- Max input: all coef=2^34-1 -> result/carry_out match a reference integer sum model; carry never exceeds 2^18-1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result stable, in_ready=0.
  - Pulse in_valid with new data in that window -> ignored.
  - Release out_ready -> IDLE next edge, in_ready=1.
- Async reset at RUN cycle 7 -> out_valid/busy=0 and in_ready=1 immediately without a clock edge. A fresh input after reset release produces the correct result 16 cycles after accept.
